aw_order_queue: RTL and testbench
=================================

# aw_order_queue

Write-order tracking queue for the AXI interconnect. It consumes the one-cycle rising-edge pulses produced by the per-master `Raising_Edge_Det` instances on each master's AWVALID. It records the index of each requesting master in arrival order. The write-data mux reads the head to select the master whose W beats are forwarded, and the head retires on the WLAST handshake.

## Interface
- `NUM_MASTERS`, 2: number of requesting masters (2..8).
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `ID_W`, max(1, clog2(NUM_MASTERS)): width of a master index (derived; do not override).
- `CNT_W`, clog2(DEPTH+1): width of the occupancy count (derived).

Ports (clock and reset first):
- `ACLK`  in  1  single clock; all state changes on its rising edge.
- `ARESETN`  in  1  asynchronous, active-low reset; deassertion is synchronous to ACLK.
- `Req_Pulse`  in  NUM_MASTERS  bit i is master i's AWVALID rising-edge pulse, one cycle wide.
- `W_Valid`  in  1  forwarded WVALID of the current head master.
- `W_Ready`  in  1  WREADY from the slave side.
- `W_Last`  in  1  WLAST of the current beat.
- `Head_Valid`  out  1  the queue holds at least one entry.
- `Head_Id`  out  ID_W  master index at the queue head; 0 when empty.
- `Count`  out  CNT_W  number of queued entries.
- `Full`  out  1  Count == DEPTH.
- `Empty`  out  1  Count == 0.
- `Overflow_Err`  out  1  sticky: a request pulse was lost.

## Operation
- Pending stage: register `pend[NUM_MASTERS]`. Bit i sets on the edge that samples `Req_Pulse[i]`=1. It clears on the edge where master i is pushed, unless `Req_Pulse[i]` is also 1 on that edge, in which case it stays set.
- Selection: round-robin among the set `pend` bits, starting at pointer `rr_ptr` (reset value 0). After a push from master i, `rr_ptr` becomes (i+1) mod NUM_MASTERS. At most one push per cycle.
- Push condition: any `pend` bit set AND (!Full OR pop). The selected index is written at the tail.
- Pop condition: `Head_Valid & W_Valid & W_Ready & W_Last`. Non-last beats never pop.
- Simultaneous push and pop: both take effect, and Count is unchanged. When Full, the pop frees the slot used by the push.
- Loss: if `Req_Pulse[i]`=1 while `pend[i]` is already set and master i is not pushed on that edge, the pulse is dropped and `Overflow_Err` sets. `Overflow_Err` clears only on reset.
- Pop while empty cannot occur, because pop is gated by Head_Valid.
- Pointers: read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately; Full and Empty are derived from Count.

## Timing
- Reset (asynchronous assert): Head_Valid=0, Head_Id=0, Count=0, Full=0, Empty=1, Overflow_Err=0, `pend`=0, `rr_ptr`=0, pointers=0.
- Latency: a pulse sampled at edge k sets `pend` at edge k. The push happens at edge k+1 if the master is selected and space exists. Head_Valid and Head_Id are then visible after edge k+1. Minimum latency is 2 edges from pulse to head.
- A pop at edge k presents the next entry (or Empty) after edge k. Back-to-back pops are allowed every cycle.
- All outputs are registered or derived from registers only; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation discards all queued and pending requests immediately.

## Structure
- Shared package `axi_ic_pkg`: `clog2` function and `ID_W`/`CNT_W` derivation helpers, reused by the arbiter and mux blocks.
- Sub-module `order_fifo`: synchronous FIFO (WIDTH=ID_W, DEPTH) with push/pop/count/full/empty. The top holds the pending register, the round-robin selector and the overflow flag.

## Test plan
- Reset: hold ARESETN=0 for 2 cycles. Require Empty=1, Count=0, Head_Valid=0, Head_Id=0, Overflow_Err=0. Then assert ARESETN=0 asynchronously between edges and require the outputs clear immediately.
- Single request: pulse `Req_Pulse`=2'b10 at edge k. Require Head_Valid=1, Head_Id=1, Count=1 after edge k+1. Send 3 beats with W_Last on the third beat only. Require Count to stay 1 until the third beat, then Empty=1.
- Simultaneous requests: pulse 2'b11 from reset. Require queue order 0 then 1, Count=2 after two pushes, `rr_ptr`=0 afterwards.
- Full and backpressure: with DEPTH=4, push 4 entries so that Full=1 and Count=4. A 5th pulse from M0 is held in `pend`. A W_Last pop then pushes it on the same edge, and Count stays 4.
- Overflow: while Full and M0 pending, pulse M0 again. Require Overflow_Err=1, still 1 after draining, and 0 only after reset.
- Reset mid-operation: with Count=3, drop ARESETN. Require Count=0, Empty=1, no stale head after release, and a fresh pulse enqueued normally.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared sizing helpers for the AXI interconnect blocks (arbiter, write mux, order queue).
package axi_ic_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A master index needs at least one bit even for a single master.
    function automatic int id_width(input int num_masters);
        return (num_masters <= 2) ? 1 : clog2(num_masters);
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/aw_order_queue_if.sv
// Request/W-beat inputs and queue status outputs of the write-order queue.
interface aw_order_queue_if #(
    parameter int NUM_MASTERS = 2,
    parameter int DEPTH       = 4
);
    localparam int ID_W  = axi_ic_pkg::id_width(NUM_MASTERS);
    localparam int CNT_W = axi_ic_pkg::cnt_width(DEPTH);

    logic [NUM_MASTERS-1:0] Req_Pulse;
    logic                   W_Valid;
    logic                   W_Ready;
    logic                   W_Last;
    logic                   Head_Valid;
    logic [ID_W-1:0]        Head_Id;
    logic [CNT_W-1:0]       Count;
    logic                   Full;
    logic                   Empty;
    logic                   Overflow_Err;

    modport master (
        output Req_Pulse, W_Valid, W_Ready, W_Last,
        input  Head_Valid, Head_Id, Count, Full, Empty, Overflow_Err
    );

    modport slave (
        input  Req_Pulse, W_Valid, W_Ready, W_Last,
        output Head_Valid, Head_Id, Count, Full, Empty, Overflow_Err
    );
endinterface

// File: rtl/order_fifo.sv
// Generic synchronous FIFO; push/pop take effect on the clock edge, head is registered (0 when empty).
// Push while full is accepted only together with a pop; pop while empty is ignored.
module order_fifo
    import axi_ic_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_push_dat,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_head_dat,
    output logic [cnt_width(DEPTH)-1:0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    // When full, the simultaneous pop frees the slot the push writes into.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/aw_order_queue.sv
// Records AW request order per master; pulse to head takes 2 edges, head retires on the WLAST handshake.
// When full, requests wait in the pending stage; a repeated pulse for a still-pending master is lost and flagged.
module aw_order_queue
    import axi_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int DEPTH       = 4
) (
    input  logic           ACLK,
    input  logic           ARESETN,
    aw_order_queue_if.slave bus
);
    localparam int ID_W  = id_width(NUM_MASTERS);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [NUM_MASTERS-1:0]   r_pend;
    logic [ID_W-1:0]          r_rr_ptr;
    logic                     r_ovf_err;

    logic [2*NUM_MASTERS-1:0] w_pend_rot2;
    logic [NUM_MASTERS-1:0]   w_pend_rot;
    logic [NUM_MASTERS-1:0]   w_push_oh;
    logic [NUM_MASTERS-1:0]   w_pend_nxt;
    int                       w_sel_off;
    int                       w_sel_idx;
    logic                     w_sel_vld;
    logic [ID_W-1:0]          w_sel_id;
    logic [ID_W-1:0]          w_rr_nxt;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_lost;
    logic                     w_full;
    logic                     w_empty;
    logic [ID_W-1:0]          w_head_id;
    logic [CNT_W-1:0]         w_count;

    // Rotate pending bits so the round-robin pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        w_pend_rot2 = {r_pend, r_pend} >> r_rr_ptr;
        w_pend_rot  = w_pend_rot2[NUM_MASTERS-1:0];
        w_sel_vld   = |w_pend_rot;
        w_sel_off   = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_pend_rot[k]) w_sel_off = k;
        end
        w_sel_idx = int'(r_rr_ptr) + w_sel_off;
        if (w_sel_idx >= NUM_MASTERS) w_sel_idx = w_sel_idx - NUM_MASTERS;
        w_sel_id = ID_W'(w_sel_idx);
    end

    assign w_pop  = ~w_empty & bus.W_Valid & bus.W_Ready & bus.W_Last;
    assign w_push = w_sel_vld & (~w_full | w_pop);

    always_comb begin
        w_push_oh  = '0;
        w_pend_nxt = '0;
        w_lost     = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_push_oh[i]  = w_push && (w_sel_idx == i);
            w_pend_nxt[i] = bus.Req_Pulse[i] | (r_pend[i] & ~w_push_oh[i]);
            if (bus.Req_Pulse[i] && r_pend[i] && !w_push_oh[i]) w_lost = 1'b1;
        end
        w_rr_nxt = (w_sel_idx == NUM_MASTERS - 1) ? '0 : ID_W'(w_sel_idx + 1);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pend    <= '0;
            r_rr_ptr  <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_push) r_rr_ptr <= w_rr_nxt;
            if (w_lost) r_ovf_err <= 1'b1;
        end
    end

    order_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_order_fifo (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .i_push     (w_push),
        .i_push_dat (w_sel_id),
        .i_pop      (w_pop),
        .o_head_dat (w_head_id),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign bus.Head_Valid   = ~w_empty;
    assign bus.Head_Id      = w_head_id;
    assign bus.Count        = w_count;
    assign bus.Full         = w_full;
    assign bus.Empty        = w_empty;
    assign bus.Overflow_Err = r_ovf_err;

endmodule

// File: tb/tb_aw_order_queue.sv
// Self-checking bench for aw_order_queue with NUM_MASTERS=2, DEPTH=4.
module tb_aw_order_queue;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   sb[$];

    aw_order_queue_if #(.NUM_MASTERS(2), .DEPTH(4)) bus ();

    aw_order_queue #(.NUM_MASTERS(2), .DEPTH(4)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic       wv;
        logic       wr;
        logic       wl;
        int         cnt;
        int         hv;
        int         hid;
        int         full;
        int         ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input int cnt, input int hv, input int hid,
                              input int full, input int ovf);
        chk({tag, " count"},  int'(bus.Count), cnt);
        chk({tag, " hvalid"}, int'(bus.Head_Valid), hv);
        chk({tag, " hid"},    int'(bus.Head_Id), hid);
        chk({tag, " full"},   int'(bus.Full), full);
        chk({tag, " empty"},  int'(bus.Empty), (cnt == 0) ? 1 : 0);
        chk({tag, " ovf"},    int'(bus.Overflow_Err), ovf);
    endtask

    // Called at a falling edge; drives one cycle of stimulus and returns at the next falling edge.
    task automatic step(input logic [1:0] req, input logic wv, input logic wr, input logic wl);
        bus.Req_Pulse = req;
        bus.W_Valid   = wv;
        bus.W_Ready   = wr;
        bus.W_Last    = wl;
        @(posedge clk);
        @(negedge clk);
        bus.Req_Pulse = '0;
        bus.W_Valid   = 1'b0;
        bus.W_Ready   = 1'b0;
        bus.W_Last    = 1'b0;
    endtask

    task automatic pop_chk(input string name);
        int exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got pop expected no pop (scoreboard empty)", name);
        end else begin
            exp = sb.pop_front();
            chk({name, " head"}, int'(bus.Head_Id), exp);
            chk({name, " hvalid"}, int'(bus.Head_Valid), 1);
        end
        step(2'b00, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{2'b10, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1, 1, 1, 0, 0};
        vecs[2]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1, 1, 1, 0, 0};
        vecs[3]  = '{2'b00, 1'b1, 1'b0, 1'b1, 1, 1, 1, 0, 0};
        vecs[4]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1, 1, 1, 0, 0};
        vecs[5]  = '{2'b00, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0};
        vecs[6]  = '{2'b11, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        vecs[7]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0};
        vecs[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0, 0};
        vecs[9]  = '{2'b00, 1'b1, 1'b1, 1'b1, 1, 1, 1, 0, 0};
        vecs[10] = '{2'b00, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0};

        rst_n         = 1'b0;
        bus.Req_Pulse = '0;
        bus.W_Valid   = 1'b0;
        bus.W_Ready   = 1'b0;
        bus.W_Last    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_status("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Single request, multi-beat burst, simultaneous requests.
        for (int v = 0; v < 11; v++) begin
            step(vecs[v].req, vecs[v].wv, vecs[v].wr, vecs[v].wl);
            chk_status($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].hv, vecs[v].hid,
                       vecs[v].full, vecs[v].ovf);
        end

        // Fill to DEPTH: two rounds of simultaneous requests, order 0,1,0,1.
        step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0); sb.push_back(0);
        step(2'b00, 1'b0, 1'b0, 1'b0); sb.push_back(1);
        step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0); sb.push_back(0);
        step(2'b00, 1'b0, 1'b0, 1'b0); sb.push_back(1);
        chk("fill full", int'(bus.Full), 1);
        chk("fill count", int'(bus.Count), 4);

        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("held count", int'(bus.Count), 4);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        chk("held count2", int'(bus.Count), 4);
        chk("held ovf", int'(bus.Overflow_Err), 0);

        // Pop while full pushes the pending M0 on the same edge.
        pop_chk("pop_push");
        sb.push_back(0);
        chk("pop_push count", int'(bus.Count), 4);
        chk("pop_push full", int'(bus.Full), 1);

        // Overflow: M0 pending while full, pulse it again.
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("pend again ovf", int'(bus.Overflow_Err), 0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("overflow set", int'(bus.Overflow_Err), 1);

        pop_chk("drain0");
        sb.push_back(0);
        chk("drain0 count", int'(bus.Count), 4);
        for (int d = 1; d <= 4; d++) pop_chk($sformatf("drain%0d", d));
        chk("drained empty", int'(bus.Empty), 1);
        chk("drained count", int'(bus.Count), 0);
        chk("drained hid", int'(bus.Head_Id), 0);
        chk("drained sb", sb.size(), 0);
        chk("overflow sticky", int'(bus.Overflow_Err), 1);

        // Reset mid-operation with three entries queued.
        step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        chk("pre-reset count", int'(bus.Count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_status("async reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b00, 1'b0, 1'b0, 1'b0);
        chk_status("post-reset", 0, 0, 0, 0, 0);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        chk("fresh latency1 hvalid", int'(bus.Head_Valid), 0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        sb.push_back(1);
        chk_status("fresh", 1, 1, 1, 0, 0);
        pop_chk("fresh pop");
        chk("fresh empty", int'(bus.Empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
